// File: rtl/priority_pkg.sv
// priority_pkg
//   Shared definitions for the registered 2-to-4 priority decoder.
//   - SEL_W_DEF   : default select index width
//   - MAX_SEL_W   : widest select the shared decode helper supports
//   - occ_t       : occupancy states of the 2-entry elastic buffer
//   - onehot_dec  : turns an encoded {v, sel} pair into a one-hot line vector
package priority_pkg;

  localparam int SEL_W_DEF = 2;

  // The decode helper returns a fixed-width vector so one function serves
  // every SEL_W up to this limit; callers keep the low 2**SEL_W bits.
  localparam int MAX_SEL_W = 8;
  localparam int MAX_N     = 2 ** MAX_SEL_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  // v = 0 means the encoder saw no active input: no line is driven and
  // sel is meaningless.
  function automatic logic [MAX_N-1:0] onehot_dec(input logic [MAX_SEL_W-1:0] sel,
                                                  input logic                 v);
    logic [MAX_N-1:0] dec;
    dec = '0;
    if (v) begin
      dec[sel] = 1'b1;
    end
    return dec;
  endfunction

endpackage

// File: rtl/dec_skid_buf.sv
// dec_skid_buf
//   Two-entry elastic buffer holding raw {v, sel} codes between a
//   valid/ready input and a valid/ready output, with an occupancy FSM.
//
// Ports
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   in_valid/ready  : upstream handshake; in_v, in_sel are the code fields
//   out_valid/ready : downstream handshake for the head entry
//   head_v, head_sel: raw fields of the head entry (meaningful when not EMPTY)
//   state           : current occupancy, exported for debug and gating
//
// Handshake rules: a transfer happens on a rising edge where valid and
// ready are both 1. in_ready depends on state only (not on out_ready), and
// out_valid depends on state only, so there is no combinational path
// between the two sides.
module dec_skid_buf
  import priority_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_v,
  input  logic [SEL_W-1:0] in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             head_v,
  output logic [SEL_W-1:0] head_sel,
  output occ_t             state
);

  occ_t state_next;

  logic             tail_v;
  logic [SEL_W-1:0] tail_sel;

  logic push;
  logic pop;

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: begin
        if (push) state_next = ONE;
      end
      ONE: begin
        if (push && !pop)      state_next = TWO;
        else if (pop && !push) state_next = EMPTY;
      end
      TWO: begin
        if (pop) state_next = ONE;
      end
      default: state_next = EMPTY;
    endcase
  end

  // Head is always the oldest entry; tail is only occupied in TWO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_v   <= 1'b0;
      head_sel <= '0;
      tail_v   <= 1'b0;
      tail_sel <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head_v   <= in_v;
            head_sel <= in_sel;
          end
        end
        ONE: begin
          if (push && pop) begin
            // Old head leaves, the new code takes its place directly.
            head_v   <= in_v;
            head_sel <= in_sel;
          end else if (push) begin
            tail_v   <= in_v;
            tail_sel <= in_sel;
          end
        end
        TWO: begin
          if (pop) begin
            head_v   <= tail_v;
            head_sel <= tail_sel;
          end
        end
        default: begin
          head_v <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/priority_decoder_2x4.sv
// priority_decoder_2x4
//   Registered decoder behind a 4x2 priority encoder. Codes {in_v, in_sel}
//   pass through a 2-entry elastic buffer; the head is decoded to a one-hot
//   line vector. Per-line saturating counters count delivered codes.
//
// Ports
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready : input handshake; in_sel = encoder y, in_v = encoder v
//   out_valid/out_ready: output handshake
//   out_onehot        : 1 << sel for the head when v = 1, else 0
//   out_none          : head entry carried v = 0
//   clr               : synchronous clear of all hit counters (wins over +1)
//   hit_cnt           : line k counter at [k*CNT_W +: CNT_W]
module priority_decoder_2x4
  import priority_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF,
  parameter int CNT_W = 8,
  localparam int N    = 2 ** SEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_v,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       out_onehot,
  output logic               out_none,
  input  logic               clr,
  output logic [N*CNT_W-1:0] hit_cnt
);

  logic             head_v;
  logic [SEL_W-1:0] head_sel;
  occ_t             occ;
  logic             active;
  logic             consume;
  logic [MAX_N-1:0] dec_full;

  logic [CNT_W-1:0] cnt [N];

  dec_skid_buf #(
    .SEL_W (SEL_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_v      (in_v),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .head_v    (head_v),
    .head_sel  (head_sel),
    .state     (occ)
  );

  assign active  = (occ != EMPTY);
  assign consume = out_valid && out_ready;

  assign dec_full   = onehot_dec(MAX_SEL_W'(head_sel), head_v);
  // Stale head contents must never leak out while the buffer is empty.
  assign out_onehot = active ? dec_full[N-1:0] : '0;
  assign out_none   = active && !head_v;

  generate
    if (N < MAX_N) begin : g_dec_hi
      logic unused_dec_hi;
      assign unused_dec_hi = ^dec_full[MAX_N-1:N];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) cnt[k] <= '0;
    end else if (clr) begin
      for (int k = 0; k < N; k++) cnt[k] <= '0;
    end else if (consume && head_v && (cnt[head_sel] != {CNT_W{1'b1}})) begin
      cnt[head_sel] <= cnt[head_sel] + 1'b1;
    end
  end

  generate
    for (genvar k = 0; k < N; k++) begin : g_pack
      assign hit_cnt[k*CNT_W +: CNT_W] = cnt[k];
    end
  endgenerate

endmodule

// File: tb/tb_priority_decoder_2x4.sv
module tb_priority_decoder_2x4;

  localparam int SEL_W = 2;
  localparam int CNT_W = 8;
  localparam int N     = 4;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [SEL_W-1:0]   in_sel;
  logic               in_v;
  logic               out_valid;
  logic               out_ready;
  logic [N-1:0]       out_onehot;
  logic               out_none;
  logic               clr;
  logic [N*CNT_W-1:0] hit_cnt;

  int tests_run;
  int tests_failed;

  logic [N-1:0] exp_q[$];

  priority_decoder_2x4 #(
    .SEL_W (SEL_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_v       (in_v),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
    .out_none   (out_none),
    .clr        (clr),
    .hit_cnt    (hit_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vector record ----------------
  typedef struct {
    logic       iv;
    logic       v;
    logic [1:0] sel;
    logic       ordy;
    logic       e_in_ready;
    logic       e_out_valid;
    logic [3:0] e_onehot;
    logic       e_none;
  } vec_t;

  vec_t vecs[14];

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic v, input logic [1:0] sel,
                       input logic ordy, input logic c);
    in_valid  = iv;
    in_v      = v;
    in_sel    = sel;
    out_ready = ordy;
    clr       = c;
  endtask

  task automatic set_vec(input int i, input logic iv, input logic v, input logic [1:0] sel,
                         input logic ordy, input logic eir, input logic eov,
                         input logic [3:0] eoh, input logic enone);
    vecs[i].iv = iv; vecs[i].v = v; vecs[i].sel = sel; vecs[i].ordy = ordy;
    vecs[i].e_in_ready = eir; vecs[i].e_out_valid = eov;
    vecs[i].e_onehot = eoh; vecs[i].e_none = enone;
  endtask

  // ---------------- test ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;

    // Each record: inputs driven this cycle, outputs expected during this
    // cycle (before the edge that samples the inputs).
    //        i   iv v sel rdy  in_rdy o_val onehot   none
    set_vec(0,  1, 1, 0, 1,   1, 0, 4'b0000, 0);
    set_vec(1,  1, 1, 1, 1,   1, 1, 4'b0001, 0);
    set_vec(2,  1, 1, 2, 1,   1, 1, 4'b0010, 0);
    set_vec(3,  1, 1, 3, 1,   1, 1, 4'b0100, 0);
    set_vec(4,  1, 0, 2, 1,   1, 1, 4'b1000, 0);
    set_vec(5,  0, 0, 0, 1,   1, 1, 4'b0000, 1);
    set_vec(6,  0, 0, 0, 1,   1, 0, 4'b0000, 0);
    // backpressure
    set_vec(7,  1, 1, 2, 0,   1, 0, 4'b0000, 0);
    set_vec(8,  1, 1, 1, 0,   1, 1, 4'b0100, 0);
    set_vec(9,  0, 0, 0, 0,   0, 1, 4'b0100, 0);
    set_vec(10, 0, 0, 0, 0,   0, 1, 4'b0100, 0);
    set_vec(11, 0, 0, 0, 1,   0, 1, 4'b0100, 0);
    set_vec(12, 0, 0, 0, 1,   1, 1, 4'b0010, 0);
    set_vec(13, 0, 0, 0, 1,   1, 0, 4'b0000, 0);

    // reset state
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_onehot", 32'(out_onehot), 32'd0);
    chk("rst_none", 32'(out_none), 32'd0);
    chk("rst_hit_cnt", hit_cnt, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // directed table: stream then backpressure
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].v, vecs[i].sel, vecs[i].ordy, 1'b0);
      #1;
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_in_ready));
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_out_valid));
      chk($sformatf("vec%0d_onehot", i), 32'(out_onehot), 32'(vecs[i].e_onehot));
      chk($sformatf("vec%0d_none", i), 32'(out_none), 32'(vecs[i].e_none));
      if (i == 6) chk("cnt_after_stream", hit_cnt, {8'd1, 8'd1, 8'd1, 8'd1});
    end
    chk("cnt_after_bp", hit_cnt, {8'd1, 8'd2, 8'd2, 8'd1});

    // steady push+pop in ONE: buffer must neither fill nor empty
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(1, 1, 2'(i % 4), 1, 0);
      #1;
      if (i > 0) begin
        chk("one_in_ready", 32'(in_ready), 32'd1);
        chk("one_out_valid", 32'(out_valid), 32'd1);
        chk("one_onehot", 32'(out_onehot), 32'(exp_q.pop_front()));
      end
      exp_q.push_back(4'b0001 << (i % 4));
    end
    @(negedge clk);
    drive(0, 0, 0, 1, 0);
    #1;
    chk("one_last_onehot", 32'(out_onehot), 32'(exp_q.pop_front()));
    @(negedge clk);
    #1;
    chk("one_drained", 32'(out_valid), 32'd0);
    chk("one_q_empty", 32'(exp_q.size()), 32'd0);
    chk("cnt_after_one", hit_cnt, {8'd6, 8'd7, 8'd7, 8'd6});

    // clear without consume
    drive(0, 0, 0, 1, 1);
    @(negedge clk);
    drive(0, 0, 0, 1, 0);
    #1;
    chk("clr_idle", hit_cnt, 32'd0);

    // saturation: 300 deliveries of line 3
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      drive(1, 1, 3, 1, 0);
    end
    @(negedge clk);
    drive(0, 0, 0, 1, 0);
    @(negedge clk);
    #1;
    chk("sat_cnt", hit_cnt, {8'd255, 8'd0, 8'd0, 8'd0});

    // clr in the same cycle as a consume of line 0
    drive(1, 1, 0, 1, 0);
    @(negedge clk);
    drive(0, 0, 0, 1, 1);
    #1;
    chk("clrpop_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    drive(0, 0, 0, 1, 0);
    #1;
    chk("clrpop_cnt", hit_cnt, 32'd0);
    chk("clrpop_empty", 32'(out_valid), 32'd0);

    // async reset while TWO, asserted between edges
    drive(1, 1, 1, 0, 0);
    @(negedge clk);
    drive(1, 1, 2, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    #1;
    chk("two_in_ready", 32'(in_ready), 32'd0);
    chk("two_onehot", 32'(out_onehot), 32'b0010);
    // bump a counter so reset has something to clear
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    drive(1, 1, 3, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    #1;
    chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
    chk("pre_rst_cnt", hit_cnt, {8'd0, 8'd0, 8'd1, 8'd0});
    #1;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_onehot", 32'(out_onehot), 32'd0);
    chk("arst_none", 32'(out_none), 32'd0);
    chk("arst_cnt", hit_cnt, 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("post_rst_no_stale", 32'(out_valid), 32'd0);
    end
    drive(1, 1, 3, 1, 0);
    @(negedge clk);
    drive(0, 0, 0, 1, 0);
    #1;
    chk("post_rst_onehot", 32'(out_onehot), 32'b1000);
    @(negedge clk);
    #1;
    chk("post_rst_drained", 32'(out_valid), 32'd0);
    chk("post_rst_cnt", hit_cnt, {8'd1, 8'd0, 8'd0, 8'd0});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
